// File: rtl/gcd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_engine: subtractive GCD of two unsigned operands, one step per clock.  |
// | Optional GCD_ITER_CNT_EN adds iter_cnt (saturating subtraction count).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic             err
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef GCD_ITER_CNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic             w_cnt_inc;
`endif

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ans_d   = ans_q;
        err_d   = err_q;
`ifdef GCD_ITER_CNT_EN
        w_cnt_inc = 1'b0;
        cnt_d     = cnt_q;
        iter_d    = iter_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    state_d = S_CALC;
`ifdef GCD_ITER_CNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_CALC: begin
                // Decision priority matters: equality first so 0/0 reports err.
                if (ra_q == rb_q) begin
                    ans_d   = ra_q;
                    err_d   = (ra_q == '0);
                    state_d = S_DONE;
                end else if (rb_q == '0) begin
                    ans_d   = ra_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (ra_q == '0) begin
                    ans_d   = rb_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (ra_q > rb_q) begin
                    ra_d = ra_q - rb_q;
`ifdef GCD_ITER_CNT_EN
                    w_cnt_inc = 1'b1;
`endif
                end else begin
                    rb_d = rb_q - ra_q;
`ifdef GCD_ITER_CNT_EN
                    w_cnt_inc = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef GCD_ITER_CNT_EN
        if (w_cnt_inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q == S_CALC) && (state_d == S_DONE)) begin
            iter_d = cnt_q;
        end
`endif
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ans_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GCD_ITER_CNT_EN
            cnt_q   <= '0;
            iter_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ans_q   <= ans_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GCD_ITER_CNT_EN
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ans  = ans_q;
    assign err  = err_q;
`ifdef GCD_ITER_CNT_EN
    assign iter_cnt = iter_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gcd_engine: directed and random GCD runs against a Euclid-based model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gcd_engine;

    localparam int WIDTH  = 16;
    localparam int BUDGET = 70000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ans;
    logic             err;
`ifdef GCD_ITER_CNT_EN
    logic [WIDTH-1:0] iter_cnt;
`endif

    int tests = 0;
    int fails = 0;

    gcd_engine #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .ans      (ans),
        .err      (err)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: Euclid by division. The subtractive count equals the sum of
    // the quotients minus one (the last step ends on equality, not on zero).
    task automatic ref_gcd(input longint x, input longint y,
                           output longint g, output longint e, output longint n);
        longint p, q, r, s;
        e = 0;
        n = 0;
        if (x == 0 && y == 0) begin
            g = 0;
            e = 1;
        end else if (x == 0 || y == 0) begin
            g = x + y;
        end else begin
            p = (x > y) ? x : y;
            q = (x > y) ? y : x;
            s = 0;
            while (q != 0) begin
                s = s + p / q;
                r = p % q;
                p = q;
                q = r;
            end
            g = p;
            n = s - 1;
            if (n > (64'd1 << WIDTH) - 1) n = (64'd1 << WIDTH) - 1;
        end
    endtask

    // Entered and left at a negedge; the next run can start immediately,
    // which places its start in the IDLE cycle right after done.
    task automatic run(input longint x, input longint y, input bit inject);
        longint g, e, n;
        int     edges, busy_cycles;
        bit     seen;
        string  id;
        ref_gcd(x, y, g, e, n);
        id    = $sformatf("(%0d,%0d)", x, y);
        a     = x[WIDTH-1:0];
        b     = y[WIDTH-1:0];
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        edges       = 0;
        busy_cycles = busy ? 1 : 0;
        seen        = 1'b0;
        if (inject) begin
            start = 1'b1;
            a     = 5;
            b     = 5;
        end
        while (edges < BUDGET) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        check({"latency", id}, seen ? 64'(edges) : 64'hFFFF_FFFF, 64'(n + 1));
        check({"busy_cycles", id}, 64'(busy_cycles), 64'(n + 1));
        check({"busy_in_done", id}, 64'(busy), 64'd0);
        check({"ans", id}, 64'(ans), 64'(g));
        check({"err", id}, 64'(err), 64'(e));
`ifdef GCD_ITER_CNT_EN
        check({"iter_cnt", id}, 64'(iter_cnt), 64'(n));
`endif
        @(posedge clk);
        @(negedge clk);
        check({"done_one_cycle", id}, 64'(done), 64'd0);
        check({"ans_hold", id}, 64'(ans), 64'(g));
    endtask

    initial begin
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ans", 64'(ans), 64'd0);
        check("rst_err", 64'(err), 64'd0);
`ifdef GCD_ITER_CNT_EN
        check("rst_iter", 64'(iter_cnt), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run(48, 18, 1'b0);
        check("ans_48_18_const", 64'(ans), 64'd6);
        run(7, 7, 1'b0);
        run(0, 0, 1'b0);
        check("err_0_0_const", 64'(err), 64'd1);
        run(0, 25, 1'b0);
        run(25, 0, 1'b0);
        run(48, 18, 1'b1);
        check("ignored_start_ans", 64'(ans), 64'd6);
        run(12, 8, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run(longint'($urandom_range(0, 300)), longint'($urandom_range(1, 300)), 1'b0);
        end

        run(1, 65535, 1'b0);

        // Abort mid-calculation with an asynchronous reset.
        a     = 48;
        b     = 18;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ans", 64'(ans), 64'd0);
        check("abort_err", 64'(err), 64'd0);
`ifdef GCD_ITER_CNT_EN
        check("abort_iter", 64'(iter_cnt), 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run(9, 6, 1'b0);
        check("after_abort_ans", 64'(ans), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
